limn2600_ram_responder: RTL

LIMN2600_RAM_RESPONDER -- requirements
Module: limn2600_ram_responder

---
 rtl/limn2600_ram_responder_if.sv | 43 ++++
 rtl/limn2600_ram_responder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/limn2600_ram_responder_if.sv
// -----------------------------------------------------------------------------
// limn2600_ram_responder_if
// Bundles the scheduler <-> RAM responder command/response signals.
//   master : scheduler side (drives ram_ce/ram_we/ram_addr/ram_data_out)
//   slave  : responder side (drives ram_data_in/ram_rdy/ram_err)
// Signals:
//   ram_ce        command enable
//   ram_we        1 = write, 0 = read (sampled with ram_ce)
//   ram_addr      byte address, bits [1:0] ignored
//   ram_data_out  write data from the scheduler
//   ram_data_in   read data to the scheduler
//   ram_rdy       single-cycle completion strobe
//   ram_err       range-error strobe, qualified by ram_rdy
// -----------------------------------------------------------------------------
interface limn2600_ram_responder_if;
   logic        ram_ce;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_data_out;
   logic [31:0] ram_data_in;
   logic        ram_rdy;
   logic        ram_err;

   modport master (
      output ram_ce,
      output ram_we,
      output ram_addr,
      output ram_data_out,
      input  ram_data_in,
      input  ram_rdy,
      input  ram_err
   );

   modport slave (
      input  ram_ce,
      input  ram_we,
      input  ram_addr,
      input  ram_data_out,
      output ram_data_in,
      output ram_rdy,
      output ram_err
   );
endinterface

// File: rtl/limn2600_ram_responder.sv
// -----------------------------------------------------------------------------
// limn2600_ram_responder
// Word-wide RAM model answering the LIMN2600 memory scheduler. A request is
// captured in IDLE, waits WAIT_STATES cycles in WAIT, completes in ACK (write
// commit or read fetch) and then spends one TURN cycle ignoring ram_ce so the
// scheduler's registered ce tail cannot re-issue the access. ram_rdy/ram_err
// and ram_data_in are registered and become visible during the TURN cycle.
//
// Parameters:
//   DEPTH_WORDS  backing-store depth in 32-bit words (power of two, >= 2)
//   WAIT_STATES  extra cycles between capture and acknowledge (0..15)
// Ports:
//   clk   single clock, rising edge
//   rst   asynchronous, active-low reset
//   bus   limn2600_ram_responder_if.slave (command in, data/strobes out)
// Build option:
//   LIMN2600_RAMRESP_RANGECHK_EN  when defined, word indices >= DEPTH_WORDS
//   are rejected (write suppressed, read returns 0, ram_err pulses with
//   ram_rdy). When undefined, ram_err is 0 and indices wrap modulo
//   DEPTH_WORDS.
// -----------------------------------------------------------------------------
module limn2600_ram_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   limn2600_ram_responder_if.slave      bus
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;
   localparam logic [1:0] ST_TURN = 2'd3;

   // Counter value loaded on WAIT entry; unused when WAIT is skipped.
   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 32'sd0) ? 4'(WAIT_STATES - 32'sd1) : 4'd0;

   logic [1:0]       state_r;
   logic [1:0]       state_nxt_s;
   logic [3:0]       cnt_r;
   logic [3:0]       cnt_nxt_s;
   logic             we_r;
   logic [IDX_W-1:0] idx_r;
   logic [31:0]      wdata_r;
   logic             oor_r;
   logic             oor_s;
   logic             rdy_r;
   logic             err_r;
   logic [31:0]      data_in_r;
   logic             unused_s;

   logic [31:0]      mem_r [DEPTH_WORDS];

`ifdef LIMN2600_RAMRESP_RANGECHK_EN
   // Range test on the full word index, not the wrapped one.
   assign oor_s       = ({2'b00, bus.ram_addr[31:2]} >= 32'(DEPTH_WORDS));
   assign bus.ram_err = err_r;
   assign unused_s    = ^bus.ram_addr[1:0];
`else
   assign oor_s       = 1'b0;
   assign bus.ram_err = 1'b0;
   assign unused_s    = ^{bus.ram_addr, err_r};
`endif

   assign bus.ram_rdy     = rdy_r;
   assign bus.ram_data_in = data_in_r;

   // Next-state and wait-counter logic.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.ram_ce) begin
               if (WAIT_STATES == 32'sd0) begin
                  state_nxt_s = ST_ACK;
               end else begin
                  state_nxt_s = ST_WAIT;
                  cnt_nxt_s   = WAIT_LOAD;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            // Dropping ce mid-wait abandons the access before anything commits.
            if (!bus.ram_ce) begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = 4'd0;
            end else if (cnt_r == 4'd0) begin
               state_nxt_s = ST_ACK;
            end else begin
               cnt_nxt_s   = cnt_r - 4'd1;
            end
         end
         ST_ACK: begin
            state_nxt_s = ST_TURN;
         end
         ST_TURN: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 4'd0;
         end
      endcase
   end

   // State, request capture and registered response outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= ST_IDLE;
         cnt_r     <= 4'd0;
         we_r      <= 1'b0;
         idx_r     <= {IDX_W{1'b0}};
         wdata_r   <= 32'h0000_0000;
         oor_r     <= 1'b0;
         rdy_r     <= 1'b0;
         err_r     <= 1'b0;
         data_in_r <= 32'h0000_0000;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         rdy_r   <= (state_r == ST_ACK);
         err_r   <= (state_r == ST_ACK) && oor_r;
         // Request fields are frozen here and used for the whole access.
         if ((state_r == ST_IDLE) && bus.ram_ce) begin
            we_r    <= bus.ram_we;
            idx_r   <= bus.ram_addr[IDX_W+1:2];
            wdata_r <= bus.ram_data_out;
            oor_r   <= oor_s;
         end
         // Read data is only replaced by a read acknowledge; writes leave it.
         if ((state_r == ST_ACK) && !we_r) begin
            data_in_r <= oor_r ? 32'h0000_0000 : mem_r[idx_r];
         end
      end
   end

   // Backing store: no reset, written only in ACK of an in-range write.
   always_ff @(posedge clk) begin
      if ((state_r == ST_ACK) && we_r && !oor_r) begin
         mem_r[idx_r] <= wdata_r;
      end
   end

endmodule
